// File: rtl/patch_scheduler.sv
// Patch scheduler: walks an image patch grid, fetching each patch into the
// cache, running the patchifier and handing the result downstream.
module patch_scheduler #(
  parameter int PATCHES_X = 4,
  parameter int PATCHES_Y = 4,
  parameter int IDX_W =
    (PATCHES_X * PATCHES_Y > 1) ? $clog2(PATCHES_X * PATCHES_Y) : 1,
  localparam int ROW_W = (PATCHES_Y > 1) ? $clog2(PATCHES_Y) : 1,
  localparam int COL_W = (PATCHES_X > 1) ? $clog2(PATCHES_X) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  output logic             busy,
  output logic             done,
  output logic             buf_req,
  input  logic             buf_ack,
  output logic [ROW_W-1:0] patch_row,
  output logic [COL_W-1:0] patch_col,
  output logic [IDX_W-1:0] patch_index,
  output logic             pf_en,
  input  logic [1:0]       pf_state,
  output logic             pf_output_taken,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_last
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LAUNCH,
    S_WAIT,
    S_EMIT,
    S_ADVANCE,
    S_FINISH
  } state_t;

  localparam logic [1:0] PF_IDLE = 2'b00;
  localparam logic [1:0] PF_DONE = 2'b10;

  state_t r_state;
  state_t w_next;

  logic [ROW_W-1:0] r_row;
  logic [COL_W-1:0] r_col;
  logic [IDX_W-1:0] r_idx;

  logic w_abort;
  logic w_last;
  logic w_col_wrap;
  logic w_pf_idle;
  logic w_pf_done;

  assign w_abort    = abort && (r_state != S_IDLE);
  assign w_col_wrap = (r_col == COL_W'(PATCHES_X - 1));
  assign w_last     = (r_row == ROW_W'(PATCHES_Y - 1)) && w_col_wrap;
  assign w_pf_idle  = (pf_state == PF_IDLE);
  assign w_pf_done  = (pf_state == PF_DONE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    if (w_abort) begin
      w_next = S_IDLE;
    end else begin
      unique case (r_state)
        S_IDLE:    if (start)     w_next = S_FETCH;
        S_FETCH:   if (buf_ack)   w_next = S_LAUNCH;
        S_LAUNCH:  if (w_pf_idle) w_next = S_WAIT;
        S_WAIT:    if (w_pf_done) w_next = S_EMIT;
        S_EMIT:    if (out_ready) w_next = S_ADVANCE;
        S_ADVANCE: w_next = w_last ? S_FINISH : S_FETCH;
        S_FINISH:  w_next = S_IDLE;
        default:   w_next = S_IDLE;
      endcase
    end
  end

  // Abort wins over any same-cycle launch, handshake or completion.
  always_comb begin
    busy            = (r_state != S_IDLE);
    done            = (r_state == S_FINISH) && !abort;
    buf_req         = (r_state == S_FETCH);
    pf_en           = (r_state == S_LAUNCH) && w_pf_idle && !abort;
    out_valid       = (r_state == S_EMIT) && !abort;
    pf_output_taken = out_valid && out_ready;
    out_last        = out_valid && w_last;
  end

  // Index advances with the grid position so it never needs a multiplier.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_row <= '0;
      r_col <= '0;
      r_idx <= '0;
    end else if (r_state == S_IDLE && start) begin
      r_row <= '0;
      r_col <= '0;
      r_idx <= '0;
    end else if (r_state == S_ADVANCE && !w_abort && !w_last) begin
      r_idx <= r_idx + IDX_W'(1);
      if (w_col_wrap) begin
        r_col <= '0;
        r_row <= r_row + ROW_W'(1);
      end else begin
        r_col <= r_col + COL_W'(1);
      end
    end
  end

  assign patch_row   = r_row;
  assign patch_col   = r_col;
  assign patch_index = r_idx;

endmodule
